// File: rtl/biquad_cascade.sv
// Cascade of Direct-Form-I biquads sharing one multiply-accumulate, one product per clock.
// Coefficients are double-buffered (shadow written by software, active used by the datapath).
module biquad_cascade #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 14,
  parameter int NUM_STAGES = 2,
  parameter int GUARD_BITS = 4,
  localparam int NUM_COEF  = 5 * NUM_STAGES,
  localparam int ADDR_W    = $clog2(NUM_COEF)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [COEF_WIDTH-1:0] cfg_data,
  input  logic                  cfg_commit,
  input  logic [NUM_STAGES-1:0] bypass,
  input  logic                  clear_state,
  output logic                  sat_flag,
  output logic                  busy
);

  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + GUARD_BITS;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int K_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [COEF_WIDTH-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]      acc_t;

  localparam coef_t   UNITY = {{(COEF_WIDTH-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};
  localparam acc_t    RND   = {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam acc_t    SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam acc_t    SAT_MIN = ~SAT_MAX;
  localparam sample_t D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam sample_t D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]     state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [2:0]     t_q, t_d;
  acc_t           acc_q, acc_d;
  sample_t        cur_x_q, cur_x_d;
  sample_t        out_data_q, out_data_d;
  logic           sat_q, sat_d;
  logic           commit_pend_q, commit_pend_d;
  logic           clear_pend_q, clear_pend_d;

  coef_t   shadow_q [NUM_COEF];
  coef_t   shadow_d [NUM_COEF];
  coef_t   active_q [NUM_COEF];
  coef_t   active_d [NUM_COEF];
  sample_t x1_q [NUM_STAGES];
  sample_t x1_d [NUM_STAGES];
  sample_t x2_q [NUM_STAGES];
  sample_t x2_d [NUM_STAGES];
  sample_t y1_q [NUM_STAGES];
  sample_t y1_d [NUM_STAGES];
  sample_t y2_q [NUM_STAGES];
  sample_t y2_d [NUM_STAGES];

  logic [ADDR_W-1:0]        coef_idx;
  coef_t                    coef;
  sample_t                  opnd;
  logic signed [PROD_W-1:0] prod;
  acc_t                     prod_ext;
  acc_t                     rnd_sum;
  acc_t                     rnd_shift;
  sample_t                  upd_r;
  logic                     upd_clip;
  sample_t                  stage_out;
  logic                     do_commit;
  logic                     do_clear;

  // Tap t of stage k selects coefficient k*5+t and the matching history operand.
  always_comb begin : datapath
    coef_idx = ADDR_W'(32'(k_q) * 32'd5 + 32'(t_q));
    coef     = active_q[coef_idx];
    case (t_q)
      3'd0:    opnd = cur_x_q;
      3'd1:    opnd = x1_q[k_q];
      3'd2:    opnd = x2_q[k_q];
      3'd3:    opnd = y1_q[k_q];
      default: opnd = y2_q[k_q];
    endcase
    prod      = PROD_W'(opnd) * PROD_W'(coef);
    prod_ext  = ACC_W'(prod);
    rnd_sum   = acc_q + RND;
    rnd_shift = rnd_sum >>> COEF_FRAC;
    upd_clip  = (rnd_shift > SAT_MAX) || (rnd_shift < SAT_MIN);
    if (rnd_shift > SAT_MAX) begin
      upd_r = D_MAX;
    end else if (rnd_shift < SAT_MIN) begin
      upd_r = D_MIN;
    end else begin
      upd_r = rnd_shift[DATA_WIDTH-1:0];
    end
    stage_out = bypass[k_q] ? cur_x_q : upd_r;
  end

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin : control
    state_d       = state_q;
    k_d           = k_q;
    t_d           = t_q;
    acc_d         = acc_q;
    cur_x_d       = cur_x_q;
    out_data_d    = out_data_q;
    sat_d         = sat_q;
    commit_pend_d = 1'b0;
    clear_pend_d  = 1'b0;
    shadow_d      = shadow_q;
    active_d      = active_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    do_commit     = 1'b0;
    do_clear      = 1'b0;

    if (cfg_we && (cfg_addr < ADDR_W'(NUM_COEF))) begin
      shadow_d[cfg_addr] = cfg_data;
    end

    case (state_q)
      S_IDLE: begin
        do_commit = cfg_commit;
        do_clear  = clear_state;
        if (in_valid) begin
          cur_x_d = in_data;
          k_d     = '0;
          t_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = (t_q < 3'd3) ? acc_q + prod_ext : acc_q - prod_ext;
        if (t_q == 3'd4) begin
          state_d = S_UPD;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      S_UPD: begin
        if (!bypass[k_q]) begin
          x2_d[k_q] = x1_q[k_q];
          x1_d[k_q] = cur_x_q;
          y2_d[k_q] = y1_q[k_q];
          y1_d[k_q] = upd_r;
          if (upd_clip) sat_d = 1'b1;
        end
        cur_x_d = stage_out;
        acc_d   = '0;
        t_d     = '0;
        if (k_q == K_W'(NUM_STAGES - 1)) begin
          out_data_d = stage_out;
          state_d    = S_OUT;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_MAC;
        end
      end
      default: begin
        if (out_ready) begin
          state_d   = S_IDLE;
          do_commit = cfg_commit | commit_pend_q;
          do_clear  = clear_state | clear_pend_q;
        end
      end
    endcase

    // Requests made while a sample is in flight wait for the edge that returns to IDLE.
    if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
      commit_pend_d = commit_pend_q | cfg_commit;
      clear_pend_d  = clear_pend_q | clear_state;
    end

    if (do_commit) active_d = shadow_d;
    if (do_clear) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        x1_d[i] = '0;
        x2_d[i] = '0;
        y1_d[i] = '0;
        y2_d[i] = '0;
      end
      sat_d = 1'b0;
    end
  end

  // NOTE: the coefficient banks and history are small register arrays and must come out of
  // reset at known values (unity passthrough, zero history), so they are reset like any flop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      t_q           <= '0;
      acc_q         <= '0;
      cur_x_q       <= '0;
      out_data_q    <= '0;
      sat_q         <= 1'b0;
      commit_pend_q <= 1'b0;
      clear_pend_q  <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= ((i % 5) == 0) ? UNITY : '0;
        active_q[i] <= ((i % 5) == 0) ? UNITY : '0;
      end
      for (int i = 0; i < NUM_STAGES; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments; all next-state math is blocking in always_comb.
      state_q       <= state_d;
      k_q           <= k_d;
      t_q           <= t_d;
      acc_q         <= acc_d;
      cur_x_q       <= cur_x_d;
      out_data_q    <= out_data_d;
      sat_q         <= sat_d;
      commit_pend_q <= commit_pend_d;
      clear_pend_q  <= clear_pend_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule
